// File: rtl/tx_vlan_insert_pkg.sv
// Shared widths, constants, state encodings and the tag-splice helper
// for the transmit-side 802.1Q tag inserter.
package tx_vlan_insert_pkg;

    localparam int DMA_DATA_WIDTH     = 256;
    localparam int DMA_KEEP_WIDTH     = 32;
    localparam int VLAN_TAG_WIDTH     = 16;
    localparam int TX_VLAN_FIFO_DEPTH = 16;
    localparam int VLAN_INS_BYTE      = 12;
    localparam int VLAN_TAG_BYTES     = 4;

    localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PASS   = 2'd1;
    localparam logic [1:0] ST_INSERT = 2'd2;
    localparam logic [1:0] ST_TAIL   = 2'd3;

    typedef struct packed {
        logic                      last;
        logic [DMA_KEEP_WIDTH-1:0] keep;
        logic [DMA_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

    localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

    // Network byte order on the wire: 0x81 lands on byte 12, TCI high byte on byte 14.
    function automatic logic [DMA_DATA_WIDTH-1:0] splice_tag(
        input logic [DMA_DATA_WIDTH-1:0] d,
        input logic [VLAN_TAG_WIDTH-1:0] tci
    );
        return {d[DMA_DATA_WIDTH-VLAN_TAG_BYTES*8-1:VLAN_INS_BYTE*8],
                tci[7:0], tci[15:8],
                ETH_TYPE_VLAN[7:0], ETH_TYPE_VLAN[15:8],
                d[VLAN_INS_BYTE*8-1:0]};
    endfunction

endpackage

// File: rtl/tx_vlan_insert_if.sv
// AXI-stream style beat bus (valid/ready/last/data/byte-enable) used on both
// sides of the tag inserter.
interface tx_vlan_insert_if;
    import tx_vlan_insert_pkg::*;

    logic                      valid;
    logic                      ready;
    logic                      last;
    logic [DMA_DATA_WIDTH-1:0] data;
    logic [DMA_KEEP_WIDTH-1:0] be;

    modport master (output valid, output last, output data, output be, input ready);
    modport slave  (input valid, input last, input data, input be, output ready);
endinterface

// File: rtl/eth_sync_fifo_2psram.sv
// Single-clock show-ahead FIFO on a two-port RAM; prog_full leaves PROG_FULL_FREE
// entries of headroom so the writer can finish an in-flight beat safely.
module eth_sync_fifo_2psram #(
    parameter int WIDTH          = 289,
    parameter int DEPTH          = 16,
    parameter int PROG_FULL_FREE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             prog_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, wr_ok, rd_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign prog_full = (count_q >= CW'(DEPTH - PROG_FULL_FREE));
    assign wr_ok     = wr_en & ~full;
    assign rd_ok     = rd_en & ~empty;
    assign rd_data   = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tx_vlan_insert.sv
// Transmit 802.1Q tag inserter: splices 0x8100+TCI at byte 12 of tagged frames,
// carrying the top 4 bytes of each beat into the next, and buffers output in a FIFO.
module tx_vlan_insert
    import tx_vlan_insert_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    tx_vlan_insert_if.slave           axis_tx,
    input  logic                      tx_vlan_valid,
    input  logic                      tx_vlan_insert_en,
    input  logic [VLAN_TAG_WIDTH-1:0] tx_vlan_tci,
    output logic                      tx_vlan_ready,
    tx_vlan_insert_if.master          axis_tx_vlan,
    output logic [31:0]               tx_vlan_tagged_cnt,
    output logic [31:0]               tx_vlan_pass_cnt
);
    logic [1:0]                state_q, state_d;
    logic [31:0]               carry_q, carry_d;
    logic [3:0]                carry_be_q, carry_be_d;
    logic [31:0]               tagged_cnt_q, tagged_cnt_d;
    logic [31:0]               pass_cnt_q, pass_cnt_d;

    logic [DMA_DATA_WIDTH-1:0] in_data;
    logic [DMA_KEEP_WIDTH-1:0] in_be;
    logic                      in_last, in_fire, tail_hi;
    logic [1:0]                ins_next;
    logic                      wr_en, wr_tagged, rd_en, fifo_empty, prog_full;
    fifo_entry_t               wr_entry, rd_entry;

    assign in_data  = axis_tx.data;
    assign in_be    = axis_tx.be;
    assign in_last  = axis_tx.last;
    assign tail_hi  = |in_be[31:28];
    assign ins_next = in_last ? (tail_hi ? ST_TAIL : ST_IDLE) : ST_INSERT;

    assign axis_tx.ready = ~prog_full & (state_q != ST_TAIL) &
                           ((state_q != ST_IDLE) | tx_vlan_valid);
    assign in_fire       = axis_tx.valid & axis_tx.ready;
    assign tx_vlan_ready = (state_q == ST_IDLE) & in_fire;

    // Splice mux: every beat of a tagged frame is shifted up by the 4 tag bytes.
    always_comb begin
        state_d      = state_q;
        carry_d      = carry_q;
        carry_be_d   = carry_be_q;
        tagged_cnt_d = tagged_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        wr_en        = 1'b0;
        wr_tagged    = 1'b0;
        wr_entry     = '0;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    wr_en = 1'b1;
                    if (!tx_vlan_insert_en || !in_be[VLAN_INS_BYTE+1]) begin
                        wr_entry.data = in_data;
                        wr_entry.keep = in_be;
                        wr_entry.last = in_last;
                        state_d       = in_last ? ST_IDLE : ST_PASS;
                    end else begin
                        wr_tagged     = 1'b1;
                        wr_entry.data = splice_tag(in_data, tx_vlan_tci);
                        wr_entry.keep = {in_be[27:12], 4'hF, in_be[11:0]};
                        wr_entry.last = in_last & ~tail_hi;
                        carry_d       = in_data[255:224];
                        carry_be_d    = in_be[31:28];
                        state_d       = ins_next;
                    end
                end
            end
            ST_PASS: begin
                if (in_fire) begin
                    wr_en         = 1'b1;
                    wr_entry.data = in_data;
                    wr_entry.keep = in_be;
                    wr_entry.last = in_last;
                    state_d       = in_last ? ST_IDLE : ST_PASS;
                end
            end
            ST_INSERT: begin
                if (in_fire) begin
                    wr_en         = 1'b1;
                    wr_tagged     = 1'b1;
                    wr_entry.data = {in_data[223:0], carry_q};
                    wr_entry.keep = {in_be[27:0], carry_be_q};
                    wr_entry.last = in_last & ~tail_hi;
                    carry_d       = in_data[255:224];
                    carry_be_d    = in_be[31:28];
                    state_d       = ins_next;
                end
            end
            default: begin
                if (!prog_full) begin
                    wr_en         = 1'b1;
                    wr_tagged     = 1'b1;
                    wr_entry.data = {224'b0, carry_q};
                    wr_entry.keep = {28'b0, carry_be_q};
                    wr_entry.last = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
        endcase
        if (wr_en && wr_entry.last) begin
            if (wr_tagged) begin
                tagged_cnt_d = tagged_cnt_q + 32'd1;
            end else begin
                pass_cnt_d = pass_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            carry_q      <= '0;
            carry_be_q   <= '0;
            tagged_cnt_q <= '0;
            pass_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            carry_q      <= carry_d;
            carry_be_q   <= carry_be_d;
            tagged_cnt_q <= tagged_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
        end
    end

    assign rd_en = axis_tx_vlan.valid & axis_tx_vlan.ready;

    eth_sync_fifo_2psram #(
        .WIDTH          (FIFO_ENTRY_W),
        .DEPTH          (TX_VLAN_FIFO_DEPTH),
        .PROG_FULL_FREE (2)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_entry),
        .rd_en     (rd_en),
        .rd_data   (rd_entry),
        .empty     (fifo_empty),
        .prog_full (prog_full)
    );

    assign axis_tx_vlan.valid = ~fifo_empty;
    assign axis_tx_vlan.last  = rd_entry.last;
    assign axis_tx_vlan.data  = rd_entry.data;
    assign axis_tx_vlan.be    = rd_entry.keep;

    assign tx_vlan_tagged_cnt = tagged_cnt_q;
    assign tx_vlan_pass_cnt   = pass_cnt_q;

endmodule

// File: tb/tb_tx_vlan_insert.sv
// Directed bench for tx_vlan_insert: hand-checked beats plus a byte-level
// insertion model feeding an output scoreboard.
module tb_tx_vlan_insert;

    typedef struct packed {
        logic         last;
        logic [31:0]  be;
        logic [255:0] data;
    } beat_t;
    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_vlan_valid, tx_vlan_insert_en, tx_vlan_ready;
    logic [15:0] tx_vlan_tci;
    logic [31:0] tagged_cnt, pass_cnt;

    int    tests_run = 0;
    int    tests_failed = 0;
    int    exp_tagged = 0;
    int    exp_pass = 0;
    int    vr_pulses = 0;
    int    stall_cnt = 0;
    int    ready_mode = 0;
    logic  timed_out = 1'b0;
    beat_t exp_q[$];
    beat_t cap_q[$];

    tx_vlan_insert_if in_if();
    tx_vlan_insert_if out_if();

    tx_vlan_insert dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .axis_tx            (in_if),
        .tx_vlan_valid      (tx_vlan_valid),
        .tx_vlan_insert_en  (tx_vlan_insert_en),
        .tx_vlan_tci        (tx_vlan_tci),
        .tx_vlan_ready      (tx_vlan_ready),
        .axis_tx_vlan       (out_if),
        .tx_vlan_tagged_cnt (tagged_cnt),
        .tx_vlan_pass_cnt   (pass_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic beat_t beatAt(input byte_q_t b, input int off);
        beat_t r;
        r = '0;
        for (int k = 0; k < 32; k++) begin
            if (off + k < b.size()) begin
                r.data[8*k +: 8] = b[off+k];
                r.be[k]          = 1'b1;
            end
        end
        r.last = (off + 32 >= b.size());
        return r;
    endfunction

    // Output ready: 0 = held low, 1 = held high, 2 = coin flip each cycle.
    initial begin
        forever begin
            case (ready_mode)
                0:       out_if.ready = 1'b0;
                1:       out_if.ready = 1'b1;
                default: out_if.ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk);
            #1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_if.valid && out_if.ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", 256'd1, 256'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                checkOutput("out_data", out_if.data, e.data);
                checkOutput("out_be", 256'(out_if.be), 256'(e.be));
                checkOutput("out_last", 256'(out_if.last), 256'(e.last));
            end
            cap_q.push_back('{last: out_if.last, be: out_if.be, data: out_if.data});
        end
        if (tx_vlan_ready) vr_pulses++;
        if (rst_n && in_if.valid && !in_if.ready) stall_cnt++;
    end

    task automatic driveBeat(input logic [255:0] d, input logic [31:0] be, input logic last);
        int waitc;
        in_if.valid = 1'b1;
        in_if.data  = d;
        in_if.be    = be;
        in_if.last  = last;
        waitc = 0;
        @(negedge clk);
        while (!in_if.ready && waitc < 3000) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_if.ready) begin
            checkOutput("in_ready_timeout", 256'd0, 256'd1);
            timed_out = 1'b1;
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input logic ins, input logic [15:0] tci, input logic [7:0] seed);
        byte_q_t fb, ob;
        beat_t   b;
        for (int i = 0; i < len; i++) fb.push_back(8'(int'(seed) + i));
        ob = fb;
        if (ins && len >= 14) begin
            ob.insert(12, 8'h81);
            ob.insert(13, 8'h00);
            ob.insert(14, tci[15:8]);
            ob.insert(15, tci[7:0]);
            exp_tagged++;
        end else begin
            exp_pass++;
        end
        for (int off = 0; off < ob.size(); off += 32) exp_q.push_back(beatAt(ob, off));
        tx_vlan_valid     = 1'b1;
        tx_vlan_insert_en = ins;
        tx_vlan_tci       = tci;
        for (int off = 0; off < len && !timed_out; off += 32) begin
            b = beatAt(fb, off);
            driveBeat(b.data, b.be, b.last);
            tx_vlan_valid = 1'b0;
        end
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput(tag, 256'(exp_q.size()), 256'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte_q_t fb;
        beat_t   b;
        rst_n             = 1'b0;
        tx_vlan_valid     = 1'b0;
        tx_vlan_insert_en = 1'b0;
        tx_vlan_tci       = '0;
        in_if.valid       = 1'b0;
        in_if.last        = 1'b0;
        in_if.data        = '0;
        in_if.be          = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 256'(out_if.valid), 256'd0);
        checkOutput("rst_in_ready", 256'(in_if.ready), 256'd0);
        checkOutput("rst_vlan_ready", 256'(tx_vlan_ready), 256'd0);
        checkOutput("rst_tagged_cnt", 256'(tagged_cnt), 256'd0);
        checkOutput("rst_pass_cnt", 256'(pass_cnt), 256'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        ready_mode = 1;
        @(posedge clk);
        #1;

        // 28B single beat, tagged: becomes exactly one full 32B beat
        cap_q.delete();
        vr_pulses = 0;
        applyStimulus(28, 1'b1, 16'h6064, 8'h00);
        waitDrain("t1_drain");
        checkOutput("t1_beats", 256'(cap_q.size()), 256'd1);
        if (cap_q.size() >= 1) begin
            checkOutput("t1_tag_bytes", 256'(cap_q[0].data[127:96]), 256'h6460_0081);
            checkOutput("t1_be", 256'(cap_q[0].be), 256'hFFFF_FFFF);
            checkOutput("t1_last", 256'(cap_q[0].last), 256'd1);
        end
        checkOutput("t1_tagged_cnt", 256'(tagged_cnt), 256'd1);
        checkOutput("t1_vlan_ready", 256'(vr_pulses), 256'd1);

        // 64B two full beats, tagged: spills a 4-byte tail beat
        cap_q.delete();
        applyStimulus(64, 1'b1, 16'h0123, 8'h00);
        waitDrain("t2_drain");
        checkOutput("t2_beats", 256'(cap_q.size()), 256'd3);
        if (cap_q.size() >= 3) begin
            checkOutput("t2_b0_tag", 256'(cap_q[0].data[127:96]), 256'h2301_0081);
            checkOutput("t2_b0_byte16", 256'(cap_q[0].data[135:128]), 256'h0C);
            checkOutput("t2_b0_last", 256'(cap_q[0].last), 256'd0);
            checkOutput("t2_b1_carry", 256'(cap_q[1].data[31:0]), 256'h1F1E_1D1C);
            checkOutput("t2_b2_be", 256'(cap_q[2].be), 256'h0000_000F);
            checkOutput("t2_b2_data", 256'(cap_q[2].data[31:0]), 256'h3F3E_3D3C);
            checkOutput("t2_b2_last", 256'(cap_q[2].last), 256'd1);
        end
        checkOutput("t2_tagged_cnt", 256'(tagged_cnt), 256'd2);

        // Untagged 60B frame, then a 13B runt that asks for a tag
        cap_q.delete();
        applyStimulus(60, 1'b0, 16'hFFFF, 8'h40);
        waitDrain("t3a_drain");
        checkOutput("t3a_beats", 256'(cap_q.size()), 256'd2);
        if (cap_q.size() >= 2) checkOutput("t3a_b1_be", 256'(cap_q[1].be), 256'h0FFF_FFFF);
        checkOutput("t3a_pass_cnt", 256'(pass_cnt), 256'd1);
        cap_q.delete();
        applyStimulus(13, 1'b1, 16'h0FFF, 8'h80);
        waitDrain("t3b_drain");
        if (cap_q.size() >= 1) checkOutput("t3b_be", 256'(cap_q[0].be), 256'h0000_1FFF);
        checkOutput("t3b_pass_cnt", 256'(pass_cnt), 256'd2);
        checkOutput("t3b_tagged_cnt", 256'(tagged_cnt), 256'd2);

        // Back-to-back frames against a stalled, then random, MAC
        ready_mode = 0;
        @(posedge clk);
        #1;
        stall_cnt = 0;
        fork
            begin
                applyStimulus(100, 1'b1, 16'hE00A, 8'h11);
                applyStimulus(64, 1'b1, 16'h2002, 8'h22);
                applyStimulus(93, 1'b1, 16'h3003, 8'h33);
                applyStimulus(14, 1'b1, 16'h4004, 8'h44);
                applyStimulus(29, 1'b1, 16'h5005, 8'h55);
                applyStimulus(61, 1'b0, 16'h6006, 8'h66);
                applyStimulus(200, 1'b1, 16'h7007, 8'h77);
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                ready_mode = 2;
            end
        join
        waitDrain("t4_drain");
        ready_mode = 1;
        checkOutput("t4_backpressure", 256'(stall_cnt >= 10), 256'd1);
        checkOutput("t4_tagged_cnt", 256'(tagged_cnt), 256'(exp_tagged));
        checkOutput("t4_pass_cnt", 256'(pass_cnt), 256'(exp_pass));

        // Beat offered with no descriptor must be held off
        @(posedge clk);
        #1;
        in_if.valid = 1'b1;
        in_if.data  = '1;
        in_if.be    = 32'hFFFF_FFFF;
        in_if.last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t5_in_ready_low", 256'(in_if.ready), 256'd0);
            checkOutput("t5_no_output", 256'(out_if.valid), 256'd0);
        end
        @(posedge clk);
        #1;
        vr_pulses = 0;
        applyStimulus(40, 1'b1, 16'hA00B, 8'h10);
        waitDrain("t5_drain");
        checkOutput("t5_vlan_ready", 256'(vr_pulses), 256'd1);

        // Reset in the middle of a tagged frame
        ready_mode = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 128; i++) fb.push_back(8'(i + 3));
        tx_vlan_valid     = 1'b1;
        tx_vlan_insert_en = 1'b1;
        tx_vlan_tci       = 16'h1234;
        b = beatAt(fb, 0);
        driveBeat(b.data, b.be, b.last);
        tx_vlan_valid = 1'b0;
        b = beatAt(fb, 32);
        driveBeat(b.data, b.be, b.last);
        @(negedge clk);
        checkOutput("t6_pre_valid", 256'(out_if.valid), 256'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_valid", 256'(out_if.valid), 256'd0);
        checkOutput("t6_rst_tagged", 256'(tagged_cnt), 256'd0);
        checkOutput("t6_rst_pass", 256'(pass_cnt), 256'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        exp_tagged = 0;
        exp_pass   = 0;
        @(negedge clk);
        checkOutput("t6_fifo_empty", 256'(out_if.valid), 256'd0);
        ready_mode = 1;
        @(posedge clk);
        #1;
        cap_q.delete();
        applyStimulus(50, 1'b1, 16'h5005, 8'h77);
        waitDrain("t6_drain");
        checkOutput("t6_beats", 256'(cap_q.size()), 256'd2);
        checkOutput("t6_tagged_cnt", 256'(tagged_cnt), 256'd1);
        checkOutput("t6_pass_cnt", 256'(pass_cnt), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
